decode_stage: RTL and testbench

- Instruction-decode stage of the in-order RV32I pipeline: fetch -> decode_stage -> execute -> memory -> writeback.
- Takes one fetched instruction per cycle and drives the register file read ports (rs*_enable/rs*_sel) combinationally, so operands arrive from the register file in the same cycle as this block's registered outputs.
- Produces a registered ID/EX control bundle for execute.
- Owns load-use hazard detection, downstream stall propagation and flush.

---
 rtl/decode_pkg.sv | 58 +++++
 rtl/decode_imm_gen.sv | 24 ++
 rtl/decode_stage.sv | 217 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, ALU ops, trap causes
// and the ID/EX control bundle.
package decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SLL  = 3'd1;
    localparam logic [2:0] ALU_SLT  = 3'd2;
    localparam logic [2:0] ALU_SLTU = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SR   = 3'd5;
    localparam logic [2:0] ALU_OR   = 3'd6;
    localparam logic [2:0] ALU_AND  = 3'd7;

    localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic       rs1_en;
        logic [4:0] rs1_sel;
        logic       rs2_en;
        logic [4:0] rs2_sel;
        logic [4:0] rd_sel;
        logic [2:0] alu_funct3;
        logic       alu_alt;
        logic       alu_src_imm;
        logic       alu_src_pc;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic [2:0] mem_funct3;
        logic       exception;
        logic [3:0] exception_cause;
    } idex_ctrl_t;

    // LB, LH, LW, LBU, LHU
    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Immediate extraction: picks the I/S/B/U/J layout from the opcode and sign-extends.
module decode_imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] instruction,
    output logic [31:0] imm
);

    logic [31:0] i;
    assign i = instruction;

    always_comb begin
        imm = '0;
        case (i[6:0])
            OPC_LUI, OPC_AUIPC: imm = {i[31:12], 12'b0};
            OPC_JAL:            imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            OPC_BRANCH:         imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            OPC_STORE:          imm = {{21{i[31]}}, i[30:25], i[11:7]};
            OPC_OP:             imm = '0;
            default:            imm = {{21{i[31]}}, i[30:20]};
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction decode: register-file read drive, load-use interlock,
// and the registered ID/EX control bundle.
module decode_stage
    import decode_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] instruction_in,
    input  logic [31:0] pc_in,
    input  logic        stall_in,
    input  logic        invalidate,
    input  logic        ex_load_valid,
    input  logic [4:0]  ex_load_rd,
    output logic        stall_out,
    output logic        rs1_enable,
    output logic        rs2_enable,
    output logic [4:0]  rs1_sel,
    output logic [4:0]  rs2_sel,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] imm_out,
    output logic [4:0]  rd_sel_out,
    output logic [2:0]  alu_funct3,
    output logic        alu_alt,
    output logic        alu_src_imm,
    output logic        alu_src_pc,
    output logic        is_load,
    output logic        is_store,
    output logic        is_branch,
    output logic        is_jal,
    output logic        is_jalr,
    output logic [2:0]  mem_funct3,
    output logic        exception_out,
    output logic [3:0]  exception_cause
);

    idex_ctrl_t  dec, ctrl_q;
    logic        vld_q;
    logic [31:0] pc_q, imm_q, imm;
    logic        use_rs1, use_rs2, has_rd, illegal;
    logic        rs1_hz, rs2_hz, hz;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;

    assign opcode = instruction_in[6:0];
    assign f3     = instruction_in[14:12];
    assign f7     = instruction_in[31:25];

    decode_imm_gen u_imm_gen (
        .instruction (instruction_in),
        .imm         (imm)
    );

    always_comb begin
        dec         = '0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        has_rd      = 1'b0;
        illegal     = 1'b0;
        dec.rs1_sel = instruction_in[19:15];
        dec.rs2_sel = instruction_in[24:20];
        if (instruction_in[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_LUI: begin
                    has_rd          = 1'b1;
                    dec.alu_src_imm = 1'b1;
                end
                OPC_AUIPC: begin
                    has_rd          = 1'b1;
                    dec.alu_src_imm = 1'b1;
                    dec.alu_src_pc  = 1'b1;
                end
                OPC_JAL: begin
                    has_rd          = 1'b1;
                    dec.is_jal      = 1'b1;
                    dec.alu_src_imm = 1'b1;
                    dec.alu_src_pc  = 1'b1;
                end
                OPC_JALR: begin
                    illegal         = (f3 != 3'd0);
                    has_rd          = 1'b1;
                    use_rs1         = 1'b1;
                    dec.is_jalr     = 1'b1;
                    dec.alu_src_imm = 1'b1;
                end
                OPC_BRANCH: begin
                    // Branch condition travels in alu_funct3; execute interprets it under is_branch.
                    illegal        = (f3[2:1] == 2'b01);
                    use_rs1        = 1'b1;
                    use_rs2        = 1'b1;
                    dec.is_branch  = 1'b1;
                    dec.alu_funct3 = f3;
                end
                OPC_LOAD: begin
                    illegal         = !load_f3_ok(f3);
                    has_rd          = 1'b1;
                    use_rs1         = 1'b1;
                    dec.is_load     = 1'b1;
                    dec.mem_funct3  = f3;
                    dec.alu_src_imm = 1'b1;
                end
                OPC_STORE: begin
                    illegal         = (f3 > 3'd2);
                    use_rs1         = 1'b1;
                    use_rs2         = 1'b1;
                    dec.is_store    = 1'b1;
                    dec.mem_funct3  = f3;
                    dec.alu_src_imm = 1'b1;
                end
                OPC_OP_IMM: begin
                    illegal = ((f3 == ALU_SLL) && (f7 != 7'd0)) ||
                              ((f3 == ALU_SR) && ((f7 & 7'b1011111) != 7'd0));
                    has_rd          = 1'b1;
                    use_rs1         = 1'b1;
                    dec.alu_funct3  = f3;
                    dec.alu_alt     = (f3 == ALU_SR) && instruction_in[30];
                    dec.alu_src_imm = 1'b1;
                end
                OPC_OP: begin
                    illegal = ((f7 & 7'b1011111) != 7'd0) ||
                              (f7[5] && (f3 != ALU_ADD) && (f3 != ALU_SR));
                    has_rd         = 1'b1;
                    use_rs1        = 1'b1;
                    use_rs2        = 1'b1;
                    dec.alu_funct3 = f3;
                    dec.alu_alt    = instruction_in[30];
                end
                OPC_MISC_MEM: illegal = (f3 != 3'd0);
                OPC_SYSTEM: begin
                    if (instruction_in == INSN_ECALL) begin
                        dec.exception       = 1'b1;
                        dec.exception_cause = CAUSE_ECALL_M;
                    end else if (instruction_in == INSN_EBREAK) begin
                        dec.exception       = 1'b1;
                        dec.exception_cause = CAUSE_BREAKPOINT;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                default: illegal = 1'b1;
            endcase
        end
        if (illegal) begin
            dec.exception       = 1'b1;
            dec.exception_cause = CAUSE_ILLEGAL;
        end
        if (dec.exception) begin
            {dec.is_load, dec.is_store, dec.is_branch, dec.is_jal, dec.is_jalr} = '0;
        end else if (has_rd) begin
            dec.rd_sel = instruction_in[11:7];
        end
        dec.rs1_en = valid_in && use_rs1;
        dec.rs2_en = valid_in && use_rs2;
    end

    // Loads already in writeback are covered by the register file's write-through.
    always_comb begin
        rs1_hz = dec.rs1_en && (dec.rs1_sel != 5'd0) &&
                 ((vld_q && ctrl_q.is_load && (ctrl_q.rd_sel == dec.rs1_sel)) ||
                  (ex_load_valid && (ex_load_rd == dec.rs1_sel)));
        rs2_hz = dec.rs2_en && (dec.rs2_sel != 5'd0) &&
                 ((vld_q && ctrl_q.is_load && (ctrl_q.rd_sel == dec.rs2_sel)) ||
                  (ex_load_valid && (ex_load_rd == dec.rs2_sel)));
        hz     = rs1_hz || rs2_hz;
    end

    assign stall_out = !invalidate && (stall_in || hz);

    // While stalled, re-read the held operands so writeback results get picked up.
    assign rs1_enable = stall_in ? (vld_q && ctrl_q.rs1_en) : dec.rs1_en;
    assign rs2_enable = stall_in ? (vld_q && ctrl_q.rs2_en) : dec.rs2_en;
    assign rs1_sel    = stall_in ? ctrl_q.rs1_sel : dec.rs1_sel;
    assign rs2_sel    = stall_in ? ctrl_q.rs2_sel : dec.rs2_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= 1'b0;
            pc_q   <= RESET_PC;
            imm_q  <= '0;
            ctrl_q <= '0;
        end else if (invalidate) begin
            vld_q <= 1'b0;
        end else if (stall_in) begin
            vld_q <= vld_q;
        end else if (hz) begin
            vld_q <= 1'b0;
        end else begin
            vld_q  <= valid_in;
            pc_q   <= pc_in;
            imm_q  <= imm;
            ctrl_q <= valid_in ? dec : '0;
        end
    end

    assign valid_out       = vld_q;
    assign pc_out          = pc_q;
    assign imm_out         = imm_q;
    assign rd_sel_out      = ctrl_q.rd_sel;
    assign alu_funct3      = ctrl_q.alu_funct3;
    assign alu_alt         = ctrl_q.alu_alt;
    assign alu_src_imm     = ctrl_q.alu_src_imm;
    assign alu_src_pc      = ctrl_q.alu_src_pc;
    assign is_load         = ctrl_q.is_load;
    assign is_store        = ctrl_q.is_store;
    assign is_branch       = ctrl_q.is_branch;
    assign is_jal          = ctrl_q.is_jal;
    assign is_jalr         = ctrl_q.is_jalr;
    assign mem_funct3      = ctrl_q.mem_funct3;
    assign exception_out   = ctrl_q.exception;
    assign exception_cause = ctrl_q.exception_cause;

endmodule

// File: tb/tb_decode_stage.sv
// Directed scenarios followed by random traffic, checked against an
// instruction-level reference model of decode and the ID/EX register.
module tb_decode_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0040;

    logic        clk, reset, valid_in, stall_in, invalidate, ex_load_valid;
    logic [31:0] instruction_in, pc_in;
    logic [4:0]  ex_load_rd;
    logic        stall_out, rs1_enable, rs2_enable, valid_out;
    logic [4:0]  rs1_sel, rs2_sel, rd_sel_out;
    logic [31:0] pc_out, imm_out;
    logic [2:0]  alu_funct3, mem_funct3;
    logic        alu_alt, alu_src_imm, alu_src_pc;
    logic        is_load, is_store, is_branch, is_jal, is_jalr, exception_out;
    logic [3:0]  exception_cause;

    decode_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .instruction_in(instruction_in),
        .pc_in(pc_in), .stall_in(stall_in), .invalidate(invalidate),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .stall_out(stall_out),
        .rs1_enable(rs1_enable), .rs2_enable(rs2_enable), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
        .valid_out(valid_out), .pc_out(pc_out), .imm_out(imm_out), .rd_sel_out(rd_sel_out),
        .alu_funct3(alu_funct3), .alu_alt(alu_alt), .alu_src_imm(alu_src_imm),
        .alu_src_pc(alu_src_pc), .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
        .is_jal(is_jal), .is_jalr(is_jalr), .mem_funct3(mem_funct3),
        .exception_out(exception_out), .exception_cause(exception_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic [2:0]  alu_f3;
        logic        alu_alt, src_imm, src_pc;
        logic        ld, st, br, jal, jalr;
        logic [2:0]  mem_f3;
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] imm;
        logic        imm_chk, alu_chk, srcimm_chk, srcpc_chk, mem_chk;
        logic        rs1_en, rs2_en;
        logic [4:0]  rs1, rs2;
    } ref_t;

    function automatic logic [31:0] sext(input int unsigned v, input int bits);
        if (v >= (32'd1 << (bits - 1))) return v - (32'd1 << bits);
        return v;
    endfunction

    // Architectural decode of one instruction, straight from the ISA tables.
    function automatic ref_t ref_decode(input logic [31:0] i);
        ref_t r;
        int unsigned u, op, f3, f7;
        logic legal;
        u = i; op = u & 127; f3 = (u >> 12) & 7; f7 = u >> 25;
        r = '{default: 0};
        r.rs1 = i[19:15]; r.rs2 = i[24:20];
        legal = 1'b0;
        if ((u & 3) == 3) begin
            case (op)
                'h37: begin legal = 1; r.rd = i[11:7]; r.imm = u & 32'hFFFF_F000; r.imm_chk = 1;
                            r.alu_chk = 1; r.src_imm = 1; r.srcimm_chk = 1; r.srcpc_chk = 1; end
                'h17: begin legal = 1; r.rd = i[11:7]; r.imm = u & 32'hFFFF_F000; r.imm_chk = 1;
                            r.src_pc = 1; r.srcpc_chk = 1; end
                'h6F: begin legal = 1; r.rd = i[11:7]; r.jal = 1; r.src_pc = 1; r.srcpc_chk = 1;
                            r.imm = sext((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                                         (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
                            r.imm_chk = 1; end
                'h67: begin legal = (f3 == 0); r.rd = i[11:7]; r.jalr = 1; r.rs1_en = 1;
                            r.imm = sext(u >> 20, 12); r.imm_chk = 1; end
                'h63: begin legal = (f3 != 2 && f3 != 3); r.br = 1; r.rs1_en = 1; r.rs2_en = 1;
                            r.imm = sext((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                                         (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
                            r.imm_chk = 1; end
                'h03: begin legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                            r.rd = i[11:7]; r.ld = 1; r.rs1_en = 1; r.mem_f3 = f3[2:0]; r.mem_chk = 1;
                            r.imm = sext(u >> 20, 12); r.imm_chk = 1; end
                'h23: begin legal = (f3 <= 2); r.st = 1; r.rs1_en = 1; r.rs2_en = 1;
                            r.mem_f3 = f3[2:0]; r.mem_chk = 1;
                            r.imm = sext(((u >> 25) << 5) | ((u >> 7) & 31), 12); r.imm_chk = 1; end
                'h13: begin legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1;
                            r.rd = i[11:7]; r.rs1_en = 1; r.alu_f3 = f3[2:0];
                            r.alu_alt = (f3 == 5) && (f7 == 32); r.alu_chk = 1;
                            r.src_imm = 1; r.srcimm_chk = 1; r.srcpc_chk = 1;
                            r.imm = sext(u >> 20, 12); r.imm_chk = 1; end
                'h33: begin legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                            r.rd = i[11:7]; r.rs1_en = 1; r.rs2_en = 1; r.alu_f3 = f3[2:0];
                            r.alu_alt = (f7 == 32); r.alu_chk = 1; r.srcimm_chk = 1; r.srcpc_chk = 1; end
                'h0F: legal = (f3 == 0);
                'h73: begin
                    if (u == 32'h73)            begin legal = 1; r.exc = 1; r.cause = 11; end
                    else if (u == 32'h0010_0073) begin legal = 1; r.exc = 1; r.cause = 3; end
                end
                default: legal = 1'b0;
            endcase
        end
        if (!legal) begin r.exc = 1; r.cause = 2; end
        if (r.exc) begin
            r.rd = 0; r.ld = 0; r.st = 0; r.br = 0; r.jal = 0; r.jalr = 0;
            r.imm_chk = 0; r.alu_chk = 0; r.srcimm_chk = 0; r.srcpc_chk = 0; r.mem_chk = 0;
        end
        return r;
    endfunction

    // ID/EX model: m_rst = reset contents, m_known = bubble/instruction contents are defined.
    logic        m_valid, m_known, m_rst;
    logic [31:0] m_pc;
    ref_t        m_r;

    task automatic check_regs();
        check("valid_out", valid_out, m_valid);
        if (m_rst) begin
            check("rst_pc", pc_out, RESET_PC);
            check("rst_imm", imm_out, 0);
            check("rst_ctrl", {rd_sel_out, alu_funct3, alu_alt, alu_src_imm, alu_src_pc, is_load,
                  is_store, is_branch, is_jal, is_jalr, mem_funct3, exception_out, exception_cause}, 0);
        end else if (m_known) begin
            check("pc_out", pc_out, m_pc);
            if (m_valid) begin
                check("rd_sel", rd_sel_out, m_r.rd);
                check("exception", exception_out, m_r.exc);
                if (m_r.exc) check("cause", exception_cause, m_r.cause);
                check("class", {is_load, is_store, is_branch, is_jal, is_jalr},
                      {m_r.ld, m_r.st, m_r.br, m_r.jal, m_r.jalr});
                if (m_r.imm_chk)    check("imm", imm_out, m_r.imm);
                if (m_r.alu_chk)    check("alu_op", {alu_funct3, alu_alt}, {m_r.alu_f3, m_r.alu_alt});
                if (m_r.srcimm_chk) check("src_imm", alu_src_imm, m_r.src_imm);
                if (m_r.srcpc_chk)  check("src_pc", alu_src_pc, m_r.src_pc);
                if (m_r.mem_chk)    check("mem_f3", mem_funct3, m_r.mem_f3);
            end else begin
                check("bubble_exc", exception_out, 0);
                check("bubble_rd", rd_sel_out, 0);
            end
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic st, input logic inv, input logic elv, input logic [4:0] elr,
                        output logic exp_stall);
        ref_t r;
        logic h1, h2;
        @(negedge clk);
        check_regs();
        reset = rst; valid_in = v; instruction_in = ins; pc_in = pc;
        stall_in = st; invalidate = inv; ex_load_valid = elv; ex_load_rd = elr;
        #1;
        r  = ref_decode(ins);
        h1 = v && r.rs1_en && r.rs1 != 0 &&
             ((m_valid && m_r.ld && m_r.rd == r.rs1) || (elv && elr == r.rs1));
        h2 = v && r.rs2_en && r.rs2 != 0 &&
             ((m_valid && m_r.ld && m_r.rd == r.rs2) || (elv && elr == r.rs2));
        exp_stall = !inv && (st || h1 || h2);
        check("stall_out", stall_out, exp_stall);
        if (!st) begin
            check("rs1_sel", rs1_sel, r.rs1);
            check("rs2_sel", rs2_sel, r.rs2);
            check("rs1_en", rs1_enable, v && r.rs1_en);
            check("rs2_en", rs2_enable, v && r.rs2_en);
        end else begin
            check("held_rs1_en", rs1_enable, m_valid && m_r.rs1_en);
            check("held_rs2_en", rs2_enable, m_valid && m_r.rs2_en);
            if (m_valid) begin
                check("held_rs1_sel", rs1_sel, m_r.rs1);
                check("held_rs2_sel", rs2_sel, m_r.rs2);
            end
        end
        if (rst) begin
            m_valid = 0; m_known = 1; m_rst = 1; m_pc = RESET_PC;
        end else if (inv) begin
            m_valid = 0; m_known = 0; m_rst = 0;
        end else if (st) begin
            // hold
        end else if (h1 || h2) begin
            m_valid = 0; m_known = 0; m_rst = 0;
        end else begin
            m_valid = v; m_known = 1; m_rst = 0; m_pc = pc; m_r = r;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, a, b;
        logic [2:0]  f3;
        logic [31:0] hi;
        rd = 5'($urandom_range(0, 3)); a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3));
        f3 = 3'($urandom_range(0, 7)); hi = $urandom;
        case ($urandom_range(0, 12))
            0:  return {($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00, b, a, f3, rd, 7'h33};
            1:  return {($urandom_range(0, 1) == 0) ? 7'h00 : hi[31:25], hi[24:20], a, f3, rd, 7'h13};
            2:  return {hi[31:20], a, f3, rd, 7'h03};
            3:  return {hi[31:25], b, a, f3, hi[11:7], 7'h23};
            4:  return {hi[31:25], b, a, f3, hi[11:7], 7'h63};
            5:  return {hi[31:12], rd, 7'h37};
            6:  return {hi[31:12], rd, 7'h17};
            7:  return {hi[31:12], rd, 7'h6F};
            8:  return {hi[31:20], a, ($urandom_range(0, 3) == 0) ? f3 : 3'd0, rd, 7'h67};
            9:  return {12'h0FF, 5'd0, ($urandom_range(0, 1) == 0) ? 3'd0 : f3, 5'd0, 7'h0F};
            10: return ($urandom_range(0, 2) == 0) ? 32'h0000_0073 :
                       ($urandom_range(0, 1) == 0) ? 32'h0010_0073 : {hi[31:7], 7'h73};
            default: return hi;
        endcase
    endfunction

    initial begin
        logic        s, v;
        logic [31:0] ins, pc;
        reset = 1; valid_in = 0; instruction_in = 0; pc_in = 0;
        stall_in = 0; invalidate = 0; ex_load_valid = 0; ex_load_rd = 0;
        m_valid = 0; m_known = 1; m_rst = 1; m_pc = RESET_PC; m_r = '{default: 0};

        step(1, 0, 32'h0, 32'h0, 0, 0, 0, 0, s);
        step(0, 1, 32'h0070_0293, 32'h100, 0, 0, 0, 0, s);   // ADDI x5,x0,7
        step(0, 1, 32'h0002_A303, 32'h104, 0, 0, 0, 0, s);   // LW x6,0(x5)
        step(0, 1, 32'h0013_03B3, 32'h108, 0, 0, 0, 0, s);   // ADD x7,x6,x1: load-use
        step(0, 1, 32'h0013_03B3, 32'h108, 0, 0, 0, 0, s);
        step(0, 1, 32'h0013_03B3, 32'h10C, 0, 0, 1, 5'd1, s); // hazard on execute-stage load
        step(0, 1, 32'h0013_03B3, 32'h10C, 0, 0, 1, 5'd0, s); // x0 never interlocks
        for (int k = 0; k < 3; k++) step(0, 1, 32'h0070_0293, 32'h110, 1, 0, 0, 0, s);
        step(0, 1, 32'h0070_0293, 32'h110, 0, 0, 0, 0, s);
        step(0, 1, 32'h0013_03B3, 32'h114, 1, 1, 0, 0, s);   // flush beats stall
        step(0, 1, 32'h0000_0000, 32'h118, 0, 0, 0, 0, s);
        step(0, 1, 32'h0000_0073, 32'h11C, 0, 0, 0, 0, s);
        step(0, 1, 32'h0010_0073, 32'h120, 0, 0, 0, 0, s);
        step(0, 0, 32'h0000_0000, 32'h124, 0, 0, 0, 0, s);   // bubble without trap
        step(0, 1, 32'h0002_A303, 32'h128, 0, 0, 0, 0, s);
        step(0, 1, 32'h0013_03B3, 32'h12C, 1, 0, 0, 0, s);
        step(1, 1, 32'h0013_03B3, 32'h12C, 1, 0, 0, 0, s);   // reset mid-stall

        s = 0; v = 1; ins = 0; pc = 32'h200;
        for (int k = 0; k < 2000; k++) begin
            if (!s) begin
                ins = rand_instr();
                v   = ($urandom_range(0, 9) != 0);
                pc  = pc + 4;
            end
            step(($urandom_range(0, 99) == 0), v, ins, pc, ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 12) == 0), ($urandom_range(0, 3) == 0),
                 5'($urandom_range(0, 3)), s);
        end
        @(negedge clk);
        check_regs();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
